// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller driving one shared external W-bit adder.
// Optional macro BOOTH_ABORT_EN adds an i_abort input that cancels an operation in progress.
module booth_r4_seq_ctrl #(
  parameter int N = 8,
  parameter int W = N + 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
`ifdef BOOTH_ABORT_EN
  input  logic             i_abort,
`endif
  input  logic [N-1:0]     i_mcand,
  input  logic [N-1:0]     i_mplier,
  output logic             o_busy,
  output logic             o_done,
  output logic [2*N-1:0]   o_product,
  output logic [W-1:0]     o_addA,
  output logic [W-1:0]     o_addB,
  input  logic [W-1:0]     i_addSum,
  input  logic             i_addCarry
);

  localparam int CW = $clog2(N / 2);

  typedef enum logic [1:0] {S_IDLE, S_NEG, S_ITER, S_DONE} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [W-1:0]    r_mx;
  logic [W-1:0]    r_negM;
  logic [W-1:0]    r_acc;
  logic [N-1:0]    r_q;
  logic            r_qm1;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_product;
  logic [W-1:0]    w_sel;
  logic            w_lastIter;
  logic            w_abort;
  logic            w_unused;

  // The carry-out of the shared adder carries no information for modulo-2^W accumulation.
  assign w_unused   = i_addCarry;
  assign w_lastIter = (r_state == S_ITER) && (r_cnt == CW'(N / 2 - 1));
  assign o_product  = r_product;

`ifdef BOOTH_ABORT_EN
  assign w_abort = i_abort && ((r_state == S_NEG) || (r_state == S_ITER));
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_sel = '0;
    unique case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_sel = r_mx;
      3'b011:         w_sel = r_mx << 1;
      3'b100:         w_sel = r_negM << 1;
      3'b101, 3'b110: w_sel = r_negM;
      default:        w_sel = '0;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    o_addA      = '0;
    o_addB      = '0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      S_IDLE: if (i_start) w_stateNext = S_NEG;
      S_NEG: begin
        o_addA      = ~r_mx;
        o_addB      = W'(1);
        o_busy      = 1'b1;
        w_stateNext = S_ITER;
      end
      S_ITER: begin
        o_addA = r_acc;
        o_addB = w_sel;
        o_busy = 1'b1;
        if (w_lastIter) w_stateNext = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (w_abort) w_stateNext = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_mx      <= '0;
      r_negM    <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_stateNext;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mx  <= {{(W-N){i_mcand[N-1]}}, i_mcand};
            r_q   <= i_mplier;
            r_qm1 <= 1'b0;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_NEG: r_negM <= i_addSum;
        S_ITER: begin
          // Arithmetic shift of {sum, Q, q_m1} by one Booth digit
          r_acc <= {{2{i_addSum[W-1]}}, i_addSum[W-1:2]};
          r_q   <= {i_addSum[1:0], r_q[N-1:2]};
          r_qm1 <= r_q[1];
          r_cnt <= r_cnt + CW'(1);
          if (w_lastIter && !w_abort) r_product <= {i_addSum[N+1:0], r_q[N-1:2]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Directed testbench for booth_r4_seq_ctrl (N=8) with a behavioural model of the shared adder.
// Also exercises i_abort when built with BOOTH_ABORT_EN.
module tb_booth_r4_seq_ctrl;

  localparam int N = 8;
  localparam int W = N + 2;

  logic            clk;
  logic            rst;
  logic            start;
  logic            abort;
  logic [N-1:0]    mcand;
  logic [N-1:0]    mplier;
  logic            busy;
  logic            done;
  logic [2*N-1:0]  product;
  logic [W-1:0]    addA;
  logic [W-1:0]    addB;
  logic [W-1:0]    addSum;
  logic            addCarry;

  int              checks;
  int              failures;
  int              edges;
  int              busyCnt;
  int              sawDone;
  int              logN;
  int              doneCnt;
  int              firstAt;
  int              secondAt;
  logic [2*N-1:0]  prod1;
  logic [2*N-1:0]  prod2;
  logic [W-1:0]    addALog [8];
  logic [W-1:0]    addBLog [8];

  booth_r4_seq_ctrl #(.N(N)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
`ifdef BOOTH_ABORT_EN
    .i_abort    (abort),
`endif
    .i_mcand    (mcand),
    .i_mplier   (mplier),
    .o_busy     (busy),
    .o_done     (done),
    .o_product  (product),
    .o_addA     (addA),
    .o_addB     (addB),
    .i_addSum   (addSum),
    .i_addCarry (addCarry)
  );

  // Shared ripple adder stands in as a plain W-bit add with carry-out.
  assign {addCarry, addSum} = {1'b0, addA} + {1'b0, addB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start with the given operands, scrambles the operand inputs once accepted,
  // and follows the operation until done or a 20-edge bound, logging adder operands.
  task automatic applyStimulus(input logic [N-1:0] mc, input logic [N-1:0] mp);
    @(negedge clk);
    mcand  = mc;
    mplier = mp;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mcand   = ~mc;
    mplier  = ~mp;
    edges   = 0;
    busyCnt = 0;
    logN    = 0;
    sawDone = 0;
    while (edges < 20) begin
      if (busy) begin
        busyCnt++;
        if (logN < 8) begin
          addALog[logN] = addA;
          addBLog[logN] = addB;
          logN++;
        end
      end
      if (done) begin
        sawDone = 1;
        break;
      end
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic runVector(input logic [N-1:0] mc, input logic [N-1:0] mp, input logic [15:0] expProd);
    applyStimulus(mc, mp);
    checkOutput("doneSeen",   sawDone, 32'd1);
    checkOutput("latency",    edges,   32'd5);
    checkOutput("busyCycles", busyCnt, 32'd5);
    checkOutput("product",    {16'h0, product}, {16'h0, expProd});
    @(posedge clk);
    #1;
    checkOutput("donePulse",   {31'h0, done}, 32'd0);
    checkOutput("productHold", {16'h0, product}, {16'h0, expProd});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    mcand    = '0;
    mplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBusy",    {31'h0, busy}, 32'd0);
    checkOutput("rstDone",    {31'h0, done}, 32'd0);
    checkOutput("rstProduct", {16'h0, product}, 32'd0);
    checkOutput("rstAddA",    {22'h0, addA}, 32'd0);
    checkOutput("rstAddB",    {22'h0, addB}, 32'd0);
    rst = 1'b0;

    runVector(8'd12, 8'd1, 16'h000C);
    runVector(8'h80, 8'h80, 16'h4000);
    runVector(8'd127, 8'h80, 16'hC080);
    runVector(8'hF9, 8'd5, 16'hFFDD);
    runVector(8'd0, 8'hFF, 16'h0000);
    checkOutput("zeroNegB", {22'h0, addBLog[0]}, 32'd1);
    for (int i = 1; i < 5; i++) checkOutput("zeroIterB", {22'h0, addBLog[i]}, 32'd0);
    runVector(8'd12, 8'hFF, 16'hFFF4);
    checkOutput("negA",   {22'h0, addALog[0]}, 32'h3F3);
    checkOutput("negB",   {22'h0, addBLog[0]}, 32'd1);
    checkOutput("iter0B", {22'h0, addBLog[1]}, 32'h3F4);
    for (int i = 2; i < 5; i++) checkOutput("iterNB", {22'h0, addBLog[i]}, 32'd0);
    runVector(8'hFF, 8'hFF, 16'h0001);
    runVector(8'd5, 8'hFD, 16'hFFF1);

    // Start held high: second operation captures only when back in IDLE.
    @(negedge clk);
    mcand  = 8'd3;
    mplier = 8'd4;
    start  = 1'b1;
    @(posedge clk);
    #1;
    mcand    = 8'd5;
    mplier   = 8'd6;
    edges    = 0;
    firstAt  = -1;
    secondAt = -1;
    prod1    = '0;
    prod2    = '0;
    while (edges < 30 && secondAt < 0) begin
      if (done) begin
        if (firstAt < 0) begin
          firstAt = edges;
          prod1   = product;
        end else begin
          secondAt = edges;
          prod2    = product;
        end
      end
      if (secondAt < 0) begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    start = 1'b0;
    checkOutput("holdFirstAt",  firstAt,  32'd5);
    checkOutput("holdFirstP",   {16'h0, prod1}, 32'd12);
    checkOutput("holdSecondAt", secondAt, 32'd12);
    checkOutput("holdSecondP",  {16'h0, prod2}, 32'd30);
    repeat (2) @(posedge clk);
    #1;

    // Reset during the third ITER cycle.
    runVector(8'hF9, 8'd5, 16'hFFDD);
    @(negedge clk);
    mcand  = 8'd3;
    mplier = 8'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midIterBusy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abortRstBusy", {31'h0, busy}, 32'd0);
    checkOutput("abortRstDone", {31'h0, done}, 32'd0);
    checkOutput("abortRstProd", {16'h0, product}, 32'd0);
    doneCnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) doneCnt++;
    end
    checkOutput("noDoneAfterRst", doneCnt, 32'd0);
    runVector(8'd12, 8'd1, 16'h000C);

`ifdef BOOTH_ABORT_EN
    runVector(8'hF9, 8'd5, 16'hFFDD);
    @(negedge clk);
    mcand  = 8'd3;
    mplier = 8'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abortBusy", {31'h0, busy}, 32'd0);
    checkOutput("abortProd", {16'h0, product}, 32'hFFDD);
    doneCnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) doneCnt++;
    end
    checkOutput("abortNoDone", doneCnt, 32'd0);
    runVector(8'd5, 8'hFD, 16'hFFF1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_ctrl.md
Name: booth_r4_seq_ctrl

Overview:
Sequential radix-4 Booth multiplier controller that time-shares one external nbit_adder instance to produce a signed 2N-bit product.
- The adder is used once to negate the multiplicand, then once per Booth digit. N/2 digits in total.
- The block owns the accumulator, the multiplier shift register, the Booth recoding and the start/done handshake.
- It sits between the top-level multiply request and the shared adder datapath.

Parameters:
- N, 8, operand width in bits. Must be even and at least 4.
- W, N+2, adder and accumulator width. Fixed as N+2; do not override.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE.
- mcand  in  N  signed multiplicand. Captured on the accepted start.
- mplier  in  N  signed multiplier. Captured on the accepted start.
- busy  out  1  high in NEG and ITER states.
- done  out  1  one-cycle pulse; product is valid in the same cycle.
- product  out  2N  signed result. Holds until the next done.
- add_a  out  W  adder operand A.
- add_b  out  W  adder operand B.
- add_sum  in  W  adder sum. Combinational return from the same cycle.
- add_carry  in  1  adder carry-out. Ignored.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE.
  - busy, done and product go to 0.
  - A, Q, q_m1, negM and the iteration counter are cleared.
  - Reset wins over every other event, including mid-ITER; no done is produced for the aborted operation.
- States: IDLE -> NEG -> ITER (N/2 cycles) -> DONE -> IDLE.
- IDLE:
  - add_a = add_b = 0.
  - On start=1: Mx <= sign-extend(mcand) to W bits; Q <= mplier; q_m1 <= 0; A <= 0; cnt <= 0; go to NEG.
- NEG (1 cycle):
  - add_a = ~Mx, add_b = 1.
  - negM <= add_sum, i.e. -Mx. For mcand = -2^(N-1) this gives +2^(N-1), which fits in W bits.
  - Go to ITER.
- ITER: each cycle decodes the triplet {Q[1],Q[0],q_m1} into sel (all values W bits, sign-correct):
  - 000, 111: sel = 0.
  - 001, 010: sel = Mx.
  - 011: sel = Mx<<1.
  - 100: sel = negM<<1.
  - 101, 110: sel = negM.
- ITER datapath, each cycle:
  - add_a = A, add_b = sel. The sum is taken modulo 2^W.
  - Arithmetic right shift by 2 of {add_sum, Q, q_m1}:
    - A <= {add_sum[W-1], add_sum[W-1], add_sum[W-1:2]}.
    - Q <= {add_sum[1:0], Q[N-1:2]}.
    - q_m1 <= Q[1].
  - cnt <= cnt+1.
- Last ITER cycle (cnt = N/2-1), at the same edge:
  - product <= {shifted A[N-1:0], shifted Q}.
  - done <= 1; go to DONE.
- DONE (1 cycle):
  - done = 1, busy = 0, add_a = add_b = 0.
  - start is ignored here. Go to IDLE.
- Latency: start sampled at edge t; done high during the cycle after edge t+N/2+1. For N=8 that is 5 edges after the start edge.
- Throughput: one multiply per N/2+3 cycles.
- start while busy or in DONE: ignored. Operands are not re-captured.
- mcand and mplier may change freely after the accepted start.
- add_a and add_b are decoded from state and registers only; they never depend on add_sum.

Optional Feature:
- Macro: BOOTH_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 at an edge while in NEG or ITER: state goes to IDLE and busy goes to 0 on the next cycle.
  - done is not pulsed and product keeps its previous value.
  - abort in IDLE or DONE has no effect.
  - rst has priority over abort.
- Not defined: the port does not exist. Operations always run to completion unless rst is asserted.

Test Plan:
- rst, then start with mcand=12, mplier=1 -> busy high for 5 cycles; done pulses exactly 5 edges after start; product=12.
- mcand=-128, mplier=-128 -> product=16384 (0x4000). Checks the negM=+128 corner.
- mcand=127, mplier=-128 -> product=-16256 (0xC080). Also mcand=-7, mplier=5 -> product=-35.
- mcand=0, mplier=-1 -> product=0. The add_b sequence over the 4 ITER cycles must be -M, 0, 0, 0 (the first digit of -1 is 110; later digits are 111).
- start held high continuously with new operands -> second operation begins only after done+1 cycle; operands changed during busy do not affect the result.
- Reset mid-ITER: assert rst during the 3rd ITER cycle -> next cycle busy=0, done=0, product=0; a following start with 12×1 still yields 12. With BOOTH_ABORT_EN, abort in ITER -> IDLE, product keeps the prior value, no done.
